// File: rtl/axi_lite_inputs_pkg.sv
// axi_lite_inputs_pkg: shared response codes, register offsets and FSM state types
package axi_lite_inputs_pkg;
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [4:0] ADDR_REG0 = 5'h00;
    localparam logic [4:0] ADDR_REG1 = 5'h04;
    localparam logic [4:0] ADDR_REG2 = 5'h08;
    localparam logic [4:0] ADDR_REG3 = 5'h0C;
    localparam logic [4:0] ADDR_STATUS = 5'h10;
    localparam logic [4:0] ADDR_EDGE = 5'h14;
    typedef enum logic {W_IDLE, W_BRESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;
    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction
    function automatic logic is_unmapped(input logic [2:0] idx);
        return idx > ADDR_EDGE[4:2];
    endfunction
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-flop synchronizer plus a rising-edge pulse on the synchronized value
module sync_edge_detect #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] sync,
    output logic [W-1:0] rise
);
    logic [W-1:0] meta, prev;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
            prev <= '0;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
        end
    end
    assign rise = sync & ~prev;
endmodule

// File: rtl/axi_lite_inputs_regs.sv
// axi_lite_inputs_regs: AXI4-Lite responder with four R/W registers, synchronized pin status
// and sticky write-1-to-clear rising-edge flags driving irq
module axi_lite_inputs_regs
    import axi_lite_inputs_pkg::*;
#(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ADDR_WIDTH = 5,
    parameter int C_NUM_INPUTS = 8
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [C_NUM_INPUTS-1:0]   in_pins,
    input  logic [C_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                S_AXI_AWPROT,
    input  logic                      S_AXI_AWVALID,
    output logic                      S_AXI_AWREADY,
    input  logic [C_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                      S_AXI_WVALID,
    output logic                      S_AXI_WREADY,
    output logic [1:0]                S_AXI_BRESP,
    output logic                      S_AXI_BVALID,
    input  logic                      S_AXI_BREADY,
    input  logic [C_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                S_AXI_ARPROT,
    input  logic                      S_AXI_ARVALID,
    output logic                      S_AXI_ARREADY,
    output logic [C_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                S_AXI_RRESP,
    output logic                      S_AXI_RVALID,
    input  logic                      S_AXI_RREADY,
    output logic                      irq
);
    wr_state_t ws, ws_n;
    rd_state_t rs, rs_n;
    logic aw_held, w_held, aw_held_n, w_held_n, awready_n, wready_n, bvalid_n, arready_n, rvalid_n;
    logic [1:0] bresp_n;
    logic [2:0] awidx_q, widx, ridx;
    logic [31:0] wdata_q, wd, wmask, rd_val;
    logic [3:0] wstrb_q;
    logic [31:0] regs [4];
    logic [C_NUM_INPUTS-1:0] pins_sync, pins_rise, edge_q, edge_clr;
    logic aw_hs, w_hs, ar_hs, commit, unused;
    sync_edge_detect #(.W(C_NUM_INPUTS)) u_sync (
        .clk(ACLK), .rst(ARESET), .d(in_pins), .sync(pins_sync), .rise(pins_rise)
    );
    assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
    assign aw_hs = S_AXI_AWREADY & S_AXI_AWVALID;
    assign w_hs = S_AXI_WREADY & S_AXI_WVALID;
    assign ar_hs = S_AXI_ARREADY & S_AXI_ARVALID;
    // AW and W may arrive in either order; use the held copy once captured, else the live bus
    assign widx = aw_held ? awidx_q : S_AXI_AWADDR[4:2];
    assign wd = w_held ? wdata_q : S_AXI_WDATA;
    assign wmask = strb_mask(w_held ? wstrb_q : S_AXI_WSTRB);
    assign commit = (ws == W_IDLE) && (aw_held | aw_hs) && (w_held | w_hs);
    assign edge_clr = (commit && widx == ADDR_EDGE[4:2]) ? wd[C_NUM_INPUTS-1:0] & wmask[C_NUM_INPUTS-1:0] : '0;
    assign ridx = S_AXI_ARADDR[4:2];
    assign rd_val = ridx == ADDR_STATUS[4:2] ? 32'(pins_sync) :
                    ridx == ADDR_EDGE[4:2] ? 32'(edge_q) :
                    ridx[2] ? 32'h0 : regs[ridx[1:0]];
    assign irq = |edge_q;
    always_comb begin
        ws_n = ws;
        aw_held_n = aw_held | aw_hs;
        w_held_n = w_held | w_hs;
        awready_n = S_AXI_AWREADY;
        wready_n = S_AXI_WREADY;
        bvalid_n = S_AXI_BVALID;
        bresp_n = S_AXI_BRESP;
        if (ws == W_IDLE) begin
            awready_n = !aw_held_n;
            wready_n = !w_held_n;
            if (commit) begin
                ws_n = W_BRESP;
                aw_held_n = 1'b0;
                w_held_n = 1'b0;
                awready_n = 1'b0;
                wready_n = 1'b0;
                bvalid_n = 1'b1;
                bresp_n = is_unmapped(widx) ? SLVERR : OKAY;
            end
        end else if (S_AXI_BREADY) begin
            ws_n = W_IDLE;
            awready_n = 1'b1;
            wready_n = 1'b1;
            bvalid_n = 1'b0;
        end
    end
    always_comb begin
        rs_n = rs;
        arready_n = S_AXI_ARREADY;
        rvalid_n = S_AXI_RVALID;
        if (rs == R_IDLE) begin
            arready_n = 1'b1;
            if (ar_hs) begin
                rs_n = R_DATA;
                arready_n = 1'b0;
                rvalid_n = 1'b1;
            end
        end else if (S_AXI_RREADY) begin
            rs_n = R_IDLE;
            arready_n = 1'b1;
            rvalid_n = 1'b0;
        end
    end
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ws <= W_IDLE;
            aw_held <= 1'b0;
            w_held <= 1'b0;
            awidx_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY <= 1'b0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP <= OKAY;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            edge_q <= '0;
        end else begin
            ws <= ws_n;
            aw_held <= aw_held_n;
            w_held <= w_held_n;
            S_AXI_AWREADY <= awready_n;
            S_AXI_WREADY <= wready_n;
            S_AXI_BVALID <= bvalid_n;
            S_AXI_BRESP <= bresp_n;
            if (aw_hs) awidx_q <= S_AXI_AWADDR[4:2];
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (commit && !widx[2]) regs[widx[1:0]] <= (regs[widx[1:0]] & ~wmask) | (wd & wmask);
            // a new rising edge wins over a same-cycle clear
            edge_q <= (edge_q & ~edge_clr) | pins_rise;
        end
    end
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rs <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA <= '0;
            S_AXI_RRESP <= OKAY;
        end else begin
            rs <= rs_n;
            S_AXI_ARREADY <= arready_n;
            S_AXI_RVALID <= rvalid_n;
            if (ar_hs) begin
                S_AXI_RDATA <= rd_val;
                S_AXI_RRESP <= is_unmapped(ridx) ? SLVERR : OKAY;
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_inputs_regs.sv
// tb_axi_lite_inputs_regs: directed bench with a response scoreboard for axi_lite_inputs_regs
module tb_axi_lite_inputs_regs;
    import axi_lite_inputs_pkg::*;
    logic ACLK = 1'b0, ARESET = 1'b1;
    logic [7:0] in_pins = '0;
    logic [4:0] S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
    logic [2:0] S_AXI_AWPROT = '0, S_AXI_ARPROT = '0;
    logic S_AXI_AWVALID = 1'b0, S_AXI_WVALID = 1'b0, S_AXI_BREADY = 1'b0;
    logic S_AXI_ARVALID = 1'b0, S_AXI_RREADY = 1'b0;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0] S_AXI_WSTRB = '0;
    logic S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, irq;
    logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
    logic [31:0] S_AXI_RDATA;
    int n_tests = 0, n_fail = 0;
    typedef struct {logic [31:0] data; logic [1:0] resp;} exp_t;
    exp_t rq[$];
    logic [1:0] bq[$];
    axi_lite_inputs_regs dut (
        .ACLK(ACLK), .ARESET(ARESET), .in_pins(in_pins),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
        .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
        .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY), .irq(irq)
    );
    always #5 ACLK = ~ACLK;
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge ACLK);
        #1;
    endtask
    function automatic logic [63:0] outs();
        return {22'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, irq,
                S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA};
    endfunction
    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] resp, input string tag);
        bit ad = 0, wdn = 0, an, wn;
        int t = 0;
        step();
        bq.push_back(resp);
        S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
        while (!(ad && wdn) && t < 20) begin
            an = S_AXI_AWREADY && S_AXI_AWVALID;
            wn = S_AXI_WREADY && S_AXI_WVALID;
            step();
            t++;
            if (an) begin ad = 1; S_AXI_AWVALID = 1'b0; end
            if (wn) begin wdn = 1; S_AXI_WVALID = 1'b0; end
        end
        chk({tag, "_accept"}, {62'b0, ad, wdn}, 64'd3);
        t = 0;
        while (!S_AXI_BVALID && t < 20) begin step(); t++; end
        chk({tag, "_bvalid"}, S_AXI_BVALID, 1);
        chk({tag, "_bresp"}, S_AXI_BRESP, bq.pop_front());
        step();
    endtask
    task automatic axi_read(input logic [4:0] a, input logic [31:0] d, input logic [1:0] resp,
                            input string tag);
        bit ad = 0, an;
        int t = 0;
        exp_t e;
        step();
        rq.push_back('{d, resp});
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        while (!ad && t < 20) begin
            an = S_AXI_ARREADY && S_AXI_ARVALID;
            step();
            t++;
            if (an) begin ad = 1; S_AXI_ARVALID = 1'b0; end
        end
        t = 0;
        while (!S_AXI_RVALID && t < 20) begin step(); t++; end
        chk({tag, "_rvalid"}, S_AXI_RVALID, 1);
        e = rq.pop_front();
        chk({tag, "_rdata"}, S_AXI_RDATA, e.data);
        chk({tag, "_rresp"}, S_AXI_RRESP, e.resp);
        step();
    endtask
    initial begin
        logic [31:0] exp_regs [4];
        exp_regs = '{32'h1, 32'h2, 32'h55, 32'h1234};
        #12;
        chk("reset_outs", outs(), 0);
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        chk("ready_before_edge", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 0);
        step();
        chk("ready_after_edge", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 64'd7);
        axi_write(5'h04, 32'hAABBCCDD, 4'b0101, OKAY, "wstrb_wr");
        axi_read(5'h04, 32'h00BB00DD, OKAY, "wstrb_rd");
        for (int i = 0; i < 4; i++) axi_write(5'(i * 4), 32'(i + 1), 4'hF, OKAY, $sformatf("reg%0d_wr", i));
        for (int i = 0; i < 4; i++) axi_read(5'(i * 4), 32'(i + 1), OKAY, $sformatf("reg%0d_rd", i));
        step();
        bq.push_back(OKAY);
        S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
        step();
        S_AXI_WVALID = 1'b0;
        chk("wfirst_wready0", S_AXI_WREADY, 0);
        chk("wfirst_nob", S_AXI_BVALID, 0);
        step();
        chk("wfirst_wready1", S_AXI_WREADY, 0);
        S_AXI_AWADDR = 5'h08; S_AXI_AWVALID = 1'b1;
        step();
        S_AXI_AWVALID = 1'b0;
        chk("wfirst_bvalid", S_AXI_BVALID, 1);
        chk("wfirst_bresp", S_AXI_BRESP, bq.pop_front());
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("wfirst_hold%0d", i), {S_AXI_BVALID, S_AXI_WREADY, S_AXI_AWREADY}, 64'd4);
            step();
        end
        S_AXI_BREADY = 1'b1;
        step();
        chk("wfirst_bdrop", S_AXI_BVALID, 0);
        axi_read(5'h08, 32'h55, OKAY, "wfirst_rd");
        axi_write(5'h0D, 32'h1234, 4'hF, OKAY, "unal_wr");
        axi_read(5'h0E, 32'h1234, OKAY, "unal_rd");
        axi_write(5'h10, 32'hFF, 4'hF, OKAY, "status_wr");
        in_pins = 8'h05;
        step();
        step();
        chk("irq_early", irq, 0);
        step();
        chk("irq_set", irq, 1);
        axi_read(5'h10, 32'h05, OKAY, "status_rd");
        axi_read(5'h14, 32'h05, OKAY, "edge_rd");
        axi_write(5'h14, 32'h01, 4'hF, OKAY, "edge_clr1");
        axi_read(5'h14, 32'h04, OKAY, "edge_rd1");
        chk("irq_still", irq, 1);
        axi_write(5'h14, 32'h04, 4'hF, OKAY, "edge_clr4");
        chk("irq_clear", irq, 0);
        axi_read(5'h14, 32'h00, OKAY, "edge_rd0");
        axi_read(5'h18, 32'h0, SLVERR, "unmap_rd");
        axi_write(5'h1C, 32'hFFFFFFFF, 4'hF, SLVERR, "unmap_wr");
        for (int i = 0; i < 4; i++) axi_read(5'(i * 4), exp_regs[i], OKAY, $sformatf("keep%0d_rd", i));
        fork
            axi_write(5'h00, 32'h99, 4'hF, OKAY, "same_wr");
            axi_read(5'h00, 32'h1, OKAY, "same_rd");
        join
        axi_read(5'h00, 32'h99, OKAY, "same_after");
        axi_write(5'h00, 32'h1, 4'hF, OKAY, "pre_rst_wr");
        in_pins = 8'h00;
        step();
        S_AXI_BREADY = 1'b0;
        S_AXI_AWADDR = 5'h0C; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'hDEAD; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        step();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        chk("rst_bvalid_pre", S_AXI_BVALID, 1);
        #2;
        ARESET = 1'b1;
        #1;
        chk("rst_async_outs", outs(), 0);
        step();
        ARESET = 1'b0;
        step();
        axi_read(5'h00, 32'h0, OKAY, "rst_reg0");
        axi_write(5'h00, 32'h77, 4'hF, OKAY, "post_rst_wr");
        axi_read(5'h00, 32'h77, OKAY, "post_rst_rd");
        chk("sb_empty", 64'(rq.size() + bq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_lite_inputs_regs.md
# axi_lite_inputs_regs

AXI4-Lite responder (slave) for the inputs peripheral. It exposes four general-purpose read/write 32-bit registers, a synchronized view of external input pins, and a sticky rising-edge capture register. It sits behind the AXI interconnect and is the target that the master VIP drives with single-beat AXI4LITE_WRITE_BURST / AXI4LITE_READ_BURST transfers.

## Interface
- C_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_ADDR_WIDTH, 5, byte address width; the block decodes addr[4:2].
- C_NUM_INPUTS, 8, number of external input pins (1..32).
- ACLK  in  1  single clock for all logic.
- ARESET  in  1  asynchronous, active-high reset.
- in_pins  in  C_NUM_INPUTS  asynchronous external inputs.
- S_AXI_AWADDR / AWPROT / AWVALID / AWREADY  in/in/in/out  C_ADDR_WIDTH/3/1/1  write address channel. AWPROT is ignored.
- S_AXI_WDATA / WSTRB / WVALID / WREADY  in/in/in/out  32/4/1/1  write data channel.
- S_AXI_BRESP / BVALID / BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR / ARPROT / ARVALID / ARREADY  in/in/in/out  C_ADDR_WIDTH/3/1/1  read address channel. ARPROT is ignored.
- S_AXI_RDATA / RRESP / RVALID / RREADY  out/out/out/in  32/2/1/1  read data channel.
- irq  out  1  high while any bit of EDGE is set.

## Operation
Register map (byte offsets):
- 0x00–0x0C: REG0–REG3. Read/write, with byte-lane writes per WSTRB. Reset value 0.
- 0x10: STATUS. Read-only; returns in_pins after a 2-flop synchronizer, zero-extended. Writes are ignored and return OKAY.
- 0x14: EDGE. Sticky per-pin rising-edge flags, set on synchronized 0→1. Write-1-to-clear, honouring WSTRB.
- 0x18–0x1C: unmapped. Reads return 0 with SLVERR; writes have no effect and return SLVERR.

Write FSM:
- States: W_IDLE, W_BRESP.
- In W_IDLE, AW and W are captured independently. AWREADY stays high until AW is latched; WREADY stays high until W is latched. AW may arrive before, after, or in the same cycle as W.
- Once both are held, the register write commits and the FSM moves to W_BRESP with BVALID=1.
- In W_BRESP, AWREADY=WREADY=0. BVALID and BRESP are held until BREADY is seen, then the FSM returns to W_IDLE.

Read FSM:
- States: R_IDLE, R_DATA.
- In R_IDLE, ARREADY=1. An accepted AR latches the address, registers RDATA/RRESP, and moves to R_DATA with RVALID=1.
- In R_DATA, ARREADY=0. RDATA, RRESP and RVALID are held until RREADY is seen.
- Read and write FSMs are fully independent. At most one write and one read are outstanding.

Boundary conditions:
- Read and write to the same register in the same cycle: the read returns the pre-write value.
- EDGE clear and a new rising edge on the same bit in the same cycle: set wins, bit stays 1.
- Address bits [1:0] are ignored (unaligned addresses are treated as aligned).
- ARESET asserted mid-transaction: every FSM returns to idle immediately and all outputs drop. A half-captured AW or W is discarded, with no response.

## Timing
Reset values:
- AWREADY, WREADY, ARREADY, BVALID, RVALID, irq: 0.
- BRESP, RRESP, RDATA: 0.
- All registers and synchronizer flops: 0.
- The READY outputs assert on the first ACLK edge after ARESET falls.

Write path:
- AW and W accepted on edge k (or the later of the two edges if they arrive separately): the register is updated and BVALID=1 at edge k+1.
- If BREADY is already high, BVALID drops at edge k+2. The next AW can be accepted at edge k+2.

Read path:
- AR accepted at edge k: RVALID and RDATA are valid at edge k+1.
- With RREADY high, the next AR is accepted at edge k+2. Sustained throughput is therefore one read per 2 cycles.

Input path:
- A pin change appears in STATUS 2 edges after it is sampled.
- The matching EDGE bit and irq are set at edge 3.

## Structure
- Package axi_lite_inputs_pkg holds:
  - resp constants: OKAY=2'b00, SLVERR=2'b10;
  - register offset localparams;
  - wr_state_t and rd_state_t enums.
- One sub-module, sync_edge_detect (parameterized width). It contains the 2-flop synchronizer, the previous-value flop and the rising-edge pulse output, and is reused by other input IPs.

## Test plan
- Write 0x1, 0x2, 0x3, 0x4 to 0x00, 0x04, 0x08, 0x0C, then read them back. Each read returns the written value with RRESP=OKAY.
- Write 0xAABBCCDD to REG1 with WSTRB=4'b0101 over a prior value of 0. Readback is 0x00BB00DD.
- Present W two cycles before AW, with BREADY held low for 5 cycles. BVALID comes 1 cycle after AW, stays stable for 5 cycles, and WREADY=0 throughout.
- Drive in_pins=0x05.
  - After 3 cycles, STATUS=0x05, EDGE=0x05 and irq=1.
  - Writing 0x01 to EDGE leaves EDGE=0x04 and irq=1.
  - Writing 0x04 to EDGE gives irq=0.
- Read 0x18 and write 0x1C. Expect RDATA=0 with RRESP=SLVERR, and BRESP=SLVERR. No register changes.
- Assert ARESET while BVALID=1 and REG0=0x1. All outputs go to 0 asynchronously, REG0 reads 0 after release, and the next write completes normally.
